// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO: round-robin packet arbitration, binary/Gray write pointer, registered full flag.
// Optional idle-lock timeout release is compiled in when ARB_TIMEOUT_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [ADDR_WIDTH:0]             wq2_rptr,
  output logic                            wen,
  output logic [ADDR_WIDTH-1:0]           waddr,
  output logic [DATA_WIDTH-1:0]           wdata,
  output logic [ADDR_WIDTH:0]             wptr,
  output logic                            wfull,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            abort
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = ADDR_WIDTH;

  if (NUM_REQ < 2 || NUM_REQ > 8 || ADDR_WIDTH < 2 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                  state, state_n;
  logic [NUM_REQ-1:0]      grant_n;
  logic [IW-1:0]           gidx, gidx_n, rr_last, rr_last_n;
  logic [IW-1:0]           hi_idx, lo_idx, pick;
  logic                    hi_vld, lo_vld;
  logic                    sel_valid, sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [AW:0]             wbin, wbin_next, wgray_next;
  logic                    full_next;

  // Rotating priority: first requester above rr_last wins, else wrap to the lowest one.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && i > int'(rr_last) && !hi_vld) begin
        hi_vld = 1'b1;
        hi_idx = IW'(i);
      end
      if (req_valid[i] && i <= int'(rr_last) && !lo_vld) begin
        lo_vld = 1'b1;
        lo_idx = IW'(i);
      end
    end
    pick = hi_vld ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(gidx) == i) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset gates the handshake so an in-flight packet is dropped immediately.
  assign req_ready  = (state == LOCK && !wfull && !rst) ? grant : '0;
  assign wen        = (state == LOCK) && sel_valid && !wfull && !rst;
  assign waddr      = wbin[AW-1:0];
  assign wdata      = sel_data;
  assign wbin_next  = wbin + {{AW{1'b0}}, wen};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;
  assign full_next  = (wgray_next == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]});

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt, idle_cnt_n;
  logic          abort_n;
`endif

  always_comb begin
    state_n   = state;
    grant_n   = grant;
    gidx_n    = gidx;
    rr_last_n = rr_last;
`ifdef ARB_TIMEOUT_EN
    idle_cnt_n = idle_cnt;
    abort_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        idle_cnt_n = '0;
`endif
        if (|req_valid) begin
          state_n = LOCK;
          gidx_n  = pick;
          for (int i = 0; i < NUM_REQ; i++) begin
            grant_n[i] = (pick == IW'(i));
          end
        end
      end
      LOCK: begin
        if (wen && sel_last) begin
          state_n   = IDLE;
          grant_n   = '0;
          rr_last_n = gidx;
        end
`ifdef ARB_TIMEOUT_EN
        // Only a missing valid counts as idle; wfull stalls with valid high do not.
        else if (!sel_valid) begin
          if (idle_cnt == CW'(TIMEOUT - 1)) begin
            abort_n    = 1'b1;
            state_n    = IDLE;
            grant_n    = '0;
            rr_last_n  = gidx;
            idle_cnt_n = '0;
          end else begin
            idle_cnt_n = idle_cnt + 1'b1;
          end
        end else begin
          idle_cnt_n = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      gidx    <= '0;
      rr_last <= IW'(NUM_REQ - 1);
      wbin    <= '0;
      wptr    <= '0;
      wfull   <= 1'b0;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      gidx    <= gidx_n;
      rr_last <= rr_last_n;
      wbin    <= wbin_next;
      wptr    <= wgray_next;
      wfull   <= full_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_n;
      abort    <= abort_n;
    end
  end
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle vector table, write scoreboard, and hand-written full/wrap/reset sequences.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  wq2_rptr;
  logic        wen;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic [3:0]  wptr;
  logic        wfull;
  logic [3:0]  grant;
  logic        abort;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .wq2_rptr(wq2_rptr), .wen(wen), .waddr(waddr), .wdata(wdata),
    .wptr(wptr), .wfull(wfull), .grant(grant), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  egrant;
    logic [3:0]  eready;
    logic        ewen;
    logic [3:0]  ewptr;
    logic        efull;
  } vec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } exp_t;

  vec_t vec[$];
  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] model = '0;
  bit   track = 1'b0;

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                     input logic [3:0] g, input logic [3:0] rdy, input logic w, input logic [3:0] p,
                     input logic f);
    vec.push_back('{r, v, l, d, g, rdy, w, p, f});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    model = '0;
  endtask

  // Present one word on requester r and wait (bounded) for it to be accepted.
  task automatic put(input int r, input logic [7:0] d, input logic l);
    int n = 0;
    req_valid[r] = 1'b1;
    req_data[r*8 +: 8] = d;
    req_last[r] = l;
    sbq.push_back('{model[2:0], d});
    model = model + 4'd1;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[r] && n < 64);
    if (!req_ready[r]) begin
      checks++;
      errors++;
      $display("FAIL put_timeout: requester %0d ready=%b required 1", r, req_ready[r]);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    req_last[r] = 1'b0;
    if (track) wq2_rptr = wptr;
  endtask

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: waddr=%0d wdata=%h with nothing expected", waddr, wdata);
      end else begin
        mon_e = sbq.pop_front();
        if ({waddr, wdata} !== {mon_e.a, mon_e.d}) begin
          errors++;
          $display("FAIL write_data: got addr %0d data %h expected addr %0d data %h",
                   waddr, wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    wq2_rptr = '0;

    // Vector table: {rst, valid, last, data} -> {grant, ready, wen, wptr, wfull}
    add(0, 4'b0100, 4'b0000, 32'h00A1_0000, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b0100, 4'b0000, 32'h00A1_0000, 4'b0100, 4'b0100, 1, 4'b0000, 0);
    add(0, 4'b0100, 4'b0000, 32'h00A2_0000, 4'b0100, 4'b0100, 1, 4'b0001, 0);
    add(0, 4'b0100, 4'b0100, 32'h00A3_0000, 4'b0100, 4'b0100, 1, 4'b0011, 0);
    add(0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 4'b0010, 0);
    add(1, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0000, 4'b0000, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0001, 4'b0001, 1, 4'b0000, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0000, 4'b0000, 0, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0010, 4'b0010, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0000, 4'b0000, 0, 4'b0011, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0100, 4'b0100, 1, 4'b0011, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0000, 4'b0000, 0, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b1000, 4'b1000, 1, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0000, 4'b0000, 0, 4'b0110, 0);
    add(0, 4'b1111, 4'b1111, 32'h1312_1110, 4'b0001, 4'b0001, 1, 4'b0110, 0);
    add(0, 4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 0, 4'b0111, 0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {grant, req_ready, wen, wptr, wfull, abort}, '0);
    @(posedge clk); #1;

    for (int i = 0; i < vec.size(); i++) begin
      rst = vec[i].rst;
      req_valid = vec[i].valid;
      req_last = vec[i].last;
      req_data = vec[i].data;
      if (vec[i].ewen) begin
        sbq.push_back('{model[2:0], vec[i].data[onehot_idx(vec[i].egrant)*8 +: 8]});
        model = model + 4'd1;
      end
      @(negedge clk);
      chk($sformatf("row%0d", i), {grant, req_ready, wen, wptr, wfull},
          {vec[i].egrant, vec[i].eready, vec[i].ewen, vec[i].ewptr, vec[i].efull});
      @(posedge clk); #1;
      if (vec[i].rst) model = '0;
    end
    rst = 1'b0;
    req_valid = '0;
    req_last = '0;

    // Fill the FIFO with the read pointer parked at 0, then free one slot at a time.
    do_reset();
    wq2_rptr = '0;
    for (int k = 0; k < 8; k++) put(0, 8'h40 + 8'(k), 1'b0);
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h48;
    chk("full_wptr", wptr, 4'b1100);
    repeat (3) begin
      @(negedge clk);
      chk("full_stall", {wfull, req_ready[0], wen}, 3'b100);
    end
    @(posedge clk); #1;
    wq2_rptr = 4'b0001;
    sbq.push_back('{model[2:0], 8'h48});
    model = model + 4'd1;
    @(negedge clk);
    chk("full_hold", {wfull, req_ready[0], wen}, 3'b100);
    @(negedge clk);
    chk("full_clear", {wfull, req_ready[0], wen, waddr}, {3'b011, 3'd0});
    @(posedge clk); #1;
    req_data[7:0] = 8'h49;
    req_last[0] = 1'b1;
    @(negedge clk);
    chk("full_again", {wfull, req_ready[0], wen}, 3'b100);
    @(posedge clk); #1;
    wq2_rptr = 4'b1100;
    sbq.push_back('{model[2:0], 8'h49});
    model = model + 4'd1;
    @(negedge clk);
    @(negedge clk);
    chk("full_resume", {wfull, req_ready[0], wen, waddr}, {3'b011, 3'd1});
    @(posedge clk); #1;
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    chk("full_release", grant, 4'b0000);

    // Sixteen writes with the read side keeping up: pointer wraps, never full.
    do_reset();
    wq2_rptr = '0;
    track = 1'b1;
    for (int k = 0; k < 16; k++) begin
      put(0, 8'h60 + 8'(k), k == 15);
      chk($sformatf("wrap%0d", k), {wfull, wptr}, {1'b0, bin2gray(model)});
    end
    track = 1'b0;

    // Reset in the middle of a packet from requester 1.
    do_reset();
    wq2_rptr = '0;
    put(1, 8'h71, 1'b0);
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'h72;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gate", {req_ready, wen}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model = '0;
    req_valid = 4'b0011;
    req_data[7:0] = 8'h80;
    @(negedge clk);
    chk("rst_state", {grant, wptr, wfull}, 9'b0);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rst_priority", grant, 4'b0001);
    put(0, 8'h81, 1'b1);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    req_valid[3] = 1'b1;
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    chk("to_grant", grant, 4'b1000);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("to_abort%0d", k), abort, (k == 16) ? 1 : 0);
    end
    chk("to_release", grant, 4'b0000);
    @(posedge clk); #1;
    chk("to_pulse_end", abort, 0);
    req_valid = 4'b1001;
    @(posedge clk); #1;
    req_valid = '0;
    chk("to_next", grant, 4'b0001);
    put(0, 8'h90, 1'b1);
`endif

    @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
